// File: rtl/csa_sub_pkg.sv
// Shared definitions for the pipelined carry-select subtractor.
// CSA_SUB_OVF_EN adds the operand sign bits to the stage-1 payload so a
// signed-overflow flag can be produced alongside the difference.
package csa_sub_pkg;

   localparam int DEFAULT_WIDTH = 5;
   localparam int DEFAULT_SPLIT = 4;
   localparam int MAX_WIDTH     = 32;

   // Stage-1 payload; fields are sized for the widest legal operand and the
   // top uses only the low bits that match its WIDTH/SPLIT.
   typedef struct packed {
      logic [MAX_WIDTH-1:0] lo_diff;
      logic                 c_mid;
      logic [MAX_WIDTH-1:0] hi_a;
      logic [MAX_WIDTH-1:0] hi_b_n;
`ifdef CSA_SUB_OVF_EN
      logic                 a_msb;
      logic                 b_msb;
`endif
   } s1_payload_t;

   // Two's-complement overflow of A-B: operands differ in sign and the
   // result sign differs from the minuend sign.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                       input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

endpackage

// File: rtl/csa_sel_slice.sv
// Carry-select slice: adds a + b_n for carry-in 0 and carry-in 1 in
// parallel and picks one result with sel (the late-arriving carry).
module csa_sel_slice #(
   parameter int W = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b_n,
   input  logic         sel,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] sum_c0;
   logic [W:0] sum_c1;

   assign sum_c0 = {1'b0, a} + {1'b0, b_n};
   assign sum_c1 = {1'b0, a} + {1'b0, b_n} + {{W{1'b0}}, 1'b1};

   assign {cout, sum} = sel ? sum_c1 : sum_c0;

endmodule

// File: rtl/csa_sub_pipe.sv
// Two-stage pipelined carry-select subtractor: diff = minuend - subtrahend
// modulo 2^WIDTH with unsigned borrow-out, valid/ready on both sides.
// Stage 1 ripples the low SPLIT bits; stage 2 selects the precomputed high
// slice with the registered mid carry.
// Optional macro CSA_SUB_OVF_EN adds a registered signed-overflow output o_ovf.
module csa_sub_pipe
   import csa_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SPLIT = DEFAULT_SPLIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_minuend,
   input  logic [WIDTH-1:0] i_subtrahend,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_borrow
`ifdef CSA_SUB_OVF_EN
   ,
   output logic             o_ovf
`endif
);

   localparam int HW = WIDTH - SPLIT;

   logic             s1_valid_reg;
   logic             s2_valid_reg;
   s1_payload_t      s1_reg;
   s1_payload_t      s1_next;
   logic [WIDTH-1:0] diff_reg;
   logic             borrow_reg;
   logic             s2_adv;
   logic             in_fire;
   logic             s1_fire;
   logic [SPLIT:0]   low_sum;
   logic [HW-1:0]    hi_sum;
   logic             hi_cout;
   logic             unused_hi;

   // Handshake: stage 2 frees up when empty or drained; stage 1 accepts
   // whenever it is empty or moving forward this cycle.
   assign s2_adv  = !s2_valid_reg || i_ready;
   assign o_ready = !s1_valid_reg || s2_adv;
   assign in_fire = i_valid && o_ready;
   assign s1_fire = s1_valid_reg && s2_adv;

   // Low ripple slice: A + ~B + 1 over the bottom SPLIT bits.
   assign low_sum = {1'b0, i_minuend[SPLIT-1:0]}
                  + {1'b0, ~i_subtrahend[SPLIT-1:0]}
                  + {{SPLIT{1'b0}}, 1'b1};

   // Assemble the stage-1 payload from the incoming operands.
   always_comb begin
      s1_next                    = '0;
      s1_next.lo_diff[SPLIT-1:0] = low_sum[SPLIT-1:0];
      s1_next.c_mid              = low_sum[SPLIT];
      s1_next.hi_a[HW-1:0]       = i_minuend[WIDTH-1:SPLIT];
      s1_next.hi_b_n[HW-1:0]     = ~i_subtrahend[WIDTH-1:SPLIT];
`ifdef CSA_SUB_OVF_EN
      s1_next.a_msb              = i_minuend[WIDTH-1];
      s1_next.b_msb              = i_subtrahend[WIDTH-1];
`endif
   end

   // Upper payload bits beyond this instance's widths are always zero.
   assign unused_hi = ^{s1_reg.lo_diff[MAX_WIDTH-1:SPLIT],
                        s1_reg.hi_a[MAX_WIDTH-1:HW],
                        s1_reg.hi_b_n[MAX_WIDTH-1:HW]};

   csa_sel_slice #(
      .W (HW)
   ) u_hi_slice (
      .a    (s1_reg.hi_a[HW-1:0]),
      .b_n  (s1_reg.hi_b_n[HW-1:0]),
      .sel  (s1_reg.c_mid),
      .sum  (hi_sum),
      .cout (hi_cout)
   );

   // Stage 1: load on input accept, otherwise empty out when drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_reg       <= '0;
      end else if (in_fire) begin
         s1_valid_reg <= 1'b1;
         s1_reg       <= s1_next;
      end else if (s1_fire) begin
         s1_valid_reg <= 1'b0;
      end
   end

   // Stage 2: select the high slice and register the result; data only
   // changes when stage 1 actually advances, so a stalled output is stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_reg <= 1'b0;
         diff_reg     <= '0;
         borrow_reg   <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            diff_reg   <= {hi_sum, s1_reg.lo_diff[SPLIT-1:0]};
            borrow_reg <= ~hi_cout;
         end
      end
   end

`ifdef CSA_SUB_OVF_EN
   logic ovf_reg;

   // Signed overflow registered alongside the difference.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else if (s1_fire) begin
         ovf_reg <= signed_ovf(s1_reg.a_msb, s1_reg.b_msb, hi_sum[HW-1]);
      end
   end

   assign o_ovf = ovf_reg;
`endif

   assign o_valid  = s2_valid_reg;
   assign o_diff   = diff_reg;
   assign o_borrow = borrow_reg;

endmodule

// File: tb/tb_csa_sub_pipe.sv
// Scoreboard bench for csa_sub_pipe (WIDTH=5, SPLIT=4): the driver pushes
// hand-computed expectations on input accept, a monitor pops and compares
// on every output transfer. Honors CSA_SUB_OVF_EN for the o_ovf port.
module tb_csa_sub_pipe;

   localparam int WIDTH = 5;
   localparam int SPLIT = 4;

   typedef struct {
      logic [WIDTH-1:0] diff;
      logic             borrow;
      logic             ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_minuend;
   logic [WIDTH-1:0] i_subtrahend;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_diff;
   logic             o_borrow;
`ifdef CSA_SUB_OVF_EN
   logic             o_ovf;
`endif

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   passed = 0;

   // Stream vectors: A, B, A-B mod 32, borrow, signed overflow.
   logic [WIDTH-1:0] st_a[8] = '{5'd12, 5'd5,  5'd31, 5'd0,  5'd20, 5'd9,  5'd17, 5'd1};
   logic [WIDTH-1:0] st_b[8] = '{5'd5,  5'd12, 5'd31, 5'd31, 5'd9,  5'd20, 5'd16, 5'd30};
   logic [WIDTH-1:0] st_d[8] = '{5'd7,  5'd25, 5'd0,  5'd1,  5'd11, 5'd21, 5'd1,  5'd3};
   logic             st_bo[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic             st_ov[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   always #5 clk = ~clk;

   csa_sub_pipe #(
      .WIDTH (WIDTH),
      .SPLIT (SPLIT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_minuend    (i_minuend),
      .i_subtrahend (i_subtrahend),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_diff       (o_diff),
      .o_borrow     (o_borrow)
`ifdef CSA_SUB_OVF_EN
      ,
      .o_ovf        (o_ovf)
`endif
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0d required %0d", name, got, exp);
   endtask

   // Monitor: compare every output transfer against the scoreboard head.
   always @(negedge clk) begin
      if (rst === 1'b0 && o_valid === 1'b1 && i_ready === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            $display("result: diff=%0d borrow=%0d (expected %0d/%0d)",
                     o_diff, o_borrow, mon_e.diff, mon_e.borrow);
            check("diff", 32'(o_diff), 32'(mon_e.diff));
            check("borrow", 32'(o_borrow), 32'(mon_e.borrow));
`ifdef CSA_SUB_OVF_EN
            check("ovf", 32'(o_ovf), 32'(mon_e.ovf));
`endif
         end
      end
   end

   // Present one operand pair, wait (bounded) for acceptance, push expectation.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] d, input logic bo, input logic ov,
                       input bit need_ready);
      int waits = 0;
      i_valid      = 1'b1;
      i_minuend    = a;
      i_subtrahend = b;
      @(negedge clk);
      while (!o_ready && waits < 50) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         waits++;
      end
      if (need_ready) check("o_ready_stream_waits", 32'(waits), 32'd0);
      if (o_ready) begin
         sb.push_back('{d, bo, ov});
         $display("issue: %0d - %0d", a, b);
      end else begin
         check("accept_timeout", 32'd0, 32'd1);
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   // Wait (bounded) until every expected result has come out.
   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || o_valid) && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_in_time", 32'(n < 60), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      i_valid      = 1'b0;
      i_ready      = 1'b1;
      i_minuend    = '0;
      i_subtrahend = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_o_valid", 32'(o_valid), 32'd0);
      check("reset_o_ready", 32'(o_ready), 32'd1);
      check("reset_o_diff", 32'(o_diff), 32'd0);
      check("reset_o_borrow", 32'(o_borrow), 32'd0);
      @(posedge clk);
      #1;

      // Basic vectors plus two-cycle latency on the first one.
      send(5'd7, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("latency_cycle1_o_valid", 32'(o_valid), 32'd0);
      @(negedge clk);
      check("latency_cycle2_o_valid", 32'(o_valid), 32'd1);
      @(posedge clk);
      #1;
      send(5'd3,  5'd7, 5'd28, 1'b1, 1'b0, 1'b0);
      send(5'd16, 5'd1, 5'd15, 1'b0, 1'b1, 1'b0);
      send(5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0);
      send(5'd15, 5'd16, 5'd31, 1'b1, 1'b1, 1'b0);
      wait_drain();

      // Back-to-back stream, o_ready must never drop.
      for (int i = 0; i < 8; i++)
         send(st_a[i], st_b[i], st_d[i], st_bo[i], st_ov[i], 1'b1);
      wait_drain();

      // Back-pressure: two accepts fill the pipe, third is held off.
      i_ready = 1'b0;
      send(5'd31, 5'd0, 5'd31, 1'b0, 1'b0, 1'b0);
      send(5'd1,  5'd2, 5'd31, 1'b1, 1'b0, 1'b0);
      i_valid      = 1'b1;
      i_minuend    = 5'd10;
      i_subtrahend = 5'd10;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_o_ready", 32'(o_ready), 32'd0);
         check("stall_o_valid", 32'(o_valid), 32'd1);
         check("stall_o_diff", 32'(o_diff), 32'd31);
         check("stall_o_borrow", 32'(o_borrow), 32'd0);
         @(posedge clk);
         #1;
      end
      i_ready = 1'b1;
      send(5'd10, 5'd10, 5'd0, 1'b0, 1'b0, 1'b0);
      wait_drain();

      // Reset with both stages full discards everything in flight.
      i_ready = 1'b0;
      send(5'd7, 5'd3, 5'd4,  1'b0, 1'b0, 1'b0);
      send(5'd3, 5'd7, 5'd28, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      i_ready = 1'b1;
      @(negedge clk);
      check("midreset_o_valid", 32'(o_valid), 32'd0);
      check("midreset_o_diff", 32'(o_diff), 32'd0);
      check("midreset_o_borrow", 32'(o_borrow), 32'd0);
      check("midreset_o_ready", 32'(o_ready), 32'd1);
      @(posedge clk);
      #1;
      send(5'd5, 5'd1, 5'd4, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("post_reset_cycle1_o_valid", 32'(o_valid), 32'd0);
      @(negedge clk);
      check("post_reset_cycle2_o_valid", 32'(o_valid), 32'd1);
      @(posedge clk);
      #1;
      wait_drain();

      @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/csa_sub_pipe.md
Name: csa_sub_pipe

Overview:
- Pipelined carry-select subtractor computing o_diff = i_minuend - i_subtrahend (mod 2^WIDTH), with an unsigned borrow-out.
- Two register stages with valid/ready handshakes on both sides. Sits downstream of operand sources in the adder-classification datapath.
- Complement of the combinational carry-select adder: the low slice ripples a borrow; the high slice is precomputed for both borrow cases and selected in stage 2.

Parameters:
- WIDTH, 5, operand and result width in bits (legal range 2..32).
- SPLIT, 4, width of the low ripple slice (1..WIDTH-1). The high select slice is WIDTH-SPLIT bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- i_valid  input  1  operand pair valid
- o_ready  output  1  block can accept operands this cycle
- i_minuend  input  WIDTH  operand A
- i_subtrahend  input  WIDTH  operand B
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_diff  output  WIDTH  A-B modulo 2^WIDTH
- o_borrow  output  1  1 when A<B (unsigned)

Behaviour:
- Arithmetic: A + ~B + 1. o_borrow = NOT carry-out of bit WIDTH-1.
- Stage 1 (on input accept):
  - Register low diff[SPLIT-1:0] = A[SPLIT-1:0] + ~B[SPLIT-1:0] + 1.
  - Register c_mid = carry out of that slice.
  - Register A[WIDTH-1:SPLIT] and ~B[WIDTH-1:SPLIT].
  - Set s1_valid.
- Stage 2 (on advance):
  - Compute high sums with carry-in 0 and carry-in 1, including each carry-out.
  - Select the pair using c_mid.
  - Register o_diff = {high_sel, low} and o_borrow = ~cout_sel. Set s2_valid.
- Latency: exactly 2 cycles from an accepted input to o_valid when there is no back-pressure. Throughput is 1 result per cycle.
- Handshake:
  - s2_adv = !s2_valid || i_ready.
  - o_ready = !s1_valid || s2_adv (combinational).
  - Input transfer occurs when i_valid && o_ready.
  - Output transfer occurs when o_valid && i_ready.
  - o_valid = s2_valid.
  - Stage 1 moves to stage 2 when s1_valid && s2_adv.
  - If stage 1 drains and no new input arrives in the same cycle, s1_valid clears.
- Stall: while o_valid && !i_ready, o_diff and o_borrow stay bit-stable.
  - Stage 1 may still hold one pending pair, so at most 2 operations are in flight.
  - o_ready deasserts only when both stages are full and i_ready=0.
- Simultaneous events:
  - Input accept plus stage-1 drain in the same cycle: stage 1 reloads with no bubble.
  - Output accept plus stage-2 reload in the same cycle: stage 2 reloads with no bubble.
- Reset (any cycle, including mid-operation):
  - Next edge clears s1_valid and s2_valid, so o_valid=0.
  - o_diff=0, o_borrow=0 and all stage data registers are 0.
  - In-flight operations are discarded.
  - o_ready=1 in the first cycle after reset.
- Wrap-around: the result is always modulo 2^WIDTH. There is no saturation.
- No X propagation: data registers load only on a stage advance.

Optional Feature:
- CSA_SUB_OVF_EN defined:
  - Adds output o_ovf (1 bit), registered alongside o_diff, reset 0.
  - o_ovf = two's-complement signed overflow: (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]).
  - Stage 1 also registers A[W-1] and B[W-1]; latency is unchanged.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package csa_sub_pkg:
  - default WIDTH/SPLIT localparams;
  - typedef for the stage-1 payload struct (low diff, c_mid, high A, high ~B, optional sign bits);
  - function computing the signed-overflow predicate.
- One sub-module, csa_sel_slice:
  - combinational, parameterized width;
  - inputs: a, b_n, sel;
  - outputs: sum and cout;
  - computes both carry-in cases internally and muxes them.
- The low ripple slice stays inline in the top module.

Test Plan:
- WIDTH=5, SPLIT=4. A=7, B=3 with i_ready=1 → two cycles later o_valid=1, o_diff=4, o_borrow=0.
- A=3, B=7 → o_diff=28, o_borrow=1. A=16, B=1 (borrow across the split) → o_diff=15, o_borrow=0. A=0, B=0 → o_diff=0, o_borrow=0.
- Back-to-back stream of 8 random pairs, i_ready=1 → one result per cycle, in order, all matching the reference model, with o_ready constantly 1.
- Hold i_ready=0 and issue 3 pairs (31-0, 1-2, 10-10):
  - o_ready drops after 2 accepts; o_diff holds 31 (o_borrow=0) stable;
  - releasing i_ready yields 31/0, then 31/1, then 0/0.
- Assert rst for one cycle while both stages are valid → next cycle o_valid=0, o_diff=0, o_borrow=0, o_ready=1; the following new pair 5-1 yields 4 after 2 cycles.
- With CSA_SUB_OVF_EN: A=15, B=16 → o_diff=31, o_ovf=1. A=16, B=1 → o_ovf=1. A=7, B=3 → o_ovf=0.
